mem_bus_arbiter: RTL

- Shares one memory bus port between two requesters: the instruction-fetch path (pc/if_id side) and the data path (mem stage).
- Grants one requester at a time and tracks exactly one outstanding transaction.
- Returns read data and a one-cycle done pulse to the granted requester.
- Raises a pipeline stall request while any request is pending, for the pipeline control logic.

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_if.sv | 56 +++++
 rtl/mem_bus_arbiter_arb_pick.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the two-requester memory bus arbiter.
// Holds the FSM state encoding, the owner encoding and a small owner helper.
package mem_bus_arbiter_pkg;

  localparam int unsigned InstAddrWidth = 32;
  localparam int unsigned InstWidth     = 32;

  localparam int unsigned ArbAddrWidth  = InstAddrWidth;
  localparam int unsigned ArbDataWidth  = InstWidth;
  localparam int unsigned ArbStateWidth = 2;

  typedef enum logic [ArbStateWidth-1:0] {
    ArbIdle = 2'd0,
    ArbAddr = 2'd1,
    ArbResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerInst = 1'b0,
    OwnerData = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e owner);
    return (owner == OwnerInst) ? OwnerData : OwnerInst;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters (fetch and data) and
// the shared memory bus slave.
//   master : arbiter view (serves the requesters, masters the memory bus)
//   slave  : environment view (requesters plus memory slave)
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SelWidth = DATA_WIDTH / 8;

  // Instruction fetch requester
  logic                  inst_req_i;
  logic [ADDR_WIDTH-1:0] inst_addr_i;
  logic [DATA_WIDTH-1:0] inst_rdata_o;
  logic                  inst_done_o;
  // Data requester
  logic                  data_req_i;
  logic                  data_we_i;
  logic [SelWidth-1:0]   data_sel_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [DATA_WIDTH-1:0] data_rdata_o;
  logic                  data_done_o;
  // Memory bus
  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [SelWidth-1:0]   bus_sel_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [DATA_WIDTH-1:0] bus_wdata_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [DATA_WIDTH-1:0] bus_rdata_i;
  // Pipeline control
  logic                  stall_req_o;

  modport master (
    input  inst_req_i, inst_addr_i,
    output inst_rdata_o, inst_done_o,
    input  data_req_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
    output data_rdata_o, data_done_o,
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output stall_req_o
  );

  modport slave (
    output inst_req_i, inst_addr_i,
    input  inst_rdata_o, inst_done_o,
    output data_req_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
    input  data_rdata_o, data_done_o,
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  stall_req_o
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational grant selection for the memory bus arbiter.
// Inputs are the already-masked requests; with ARB_ROUND_ROBIN_EN defined a
// tie goes to the requester named by rr_ptr_i, otherwise data always wins.
//   inst_req_i / data_req_i : masked requests
//   rr_ptr_i                : preferred owner on a tie (round-robin build only)
//   grant_valid_o           : some request is grantable
//   grant_owner_o           : which requester gets the grant
module mem_bus_arbiter_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic   inst_req_i,
  input  logic   data_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e rr_ptr_i,
`endif
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

  always_comb begin
    grant_valid_o = inst_req_i | data_req_i;
    grant_owner_o = OwnerInst;
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_req_i && data_req_i) begin
      grant_owner_o = rr_ptr_i;
    end else if (data_req_i) begin
      grant_owner_o = OwnerData;
    end
`else
    if (data_req_i) begin
      grant_owner_o = OwnerData;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus port between instruction fetch and the data path.
// One transaction is outstanding at a time: IDLE picks an owner and latches
// its request into the bus_* registers, ADDR holds bus_req_o until bus_gnt_i,
// RESP waits for bus_rvalid_i and returns data with a one-cycle done pulse.
// Fetches are issued as reads with all byte enables set and zero write data.
// Optional macro ARB_ROUND_ROBIN_EN: on a tie grant the requester not granted
// last; otherwise data has fixed priority over fetch.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   arb_bus : requester, memory bus and stall signals (master modport)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ArbAddrWidth,
  parameter int unsigned DATA_WIDTH = ArbDataWidth
) (
  input logic                clk,
  input logic                rst,
  mem_bus_arbiter_if.master  arb_bus
);

  localparam int unsigned SelWidth = DATA_WIDTH / 8;

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  bus_we_q, bus_we_d;
  logic [SelWidth-1:0]   bus_sel_q, bus_sel_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  inst_done_q, inst_done_d;
  logic                  data_done_q, data_done_d;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e                rr_ptr_q, rr_ptr_d;
`endif

  logic   inst_req_m, data_req_m;
  logic   grant_valid;
  owner_e grant_owner;

  // A requester still holding req during its done cycle must not be re-granted.
  assign inst_req_m = arb_bus.inst_req_i & ~inst_done_q;
  assign data_req_m = arb_bus.data_req_i & ~data_done_q;

  mem_bus_arbiter_arb_pick u_arb_pick (
    .inst_req_i    (inst_req_m),
    .data_req_i    (data_req_m),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr_i      (rr_ptr_q),
`endif
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_we_d     = bus_we_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      ArbIdle: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          state_d = ArbAddr;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d = other_owner(grant_owner);
`endif
          if (grant_owner == OwnerData) begin
            bus_we_d    = arb_bus.data_we_i;
            bus_sel_d   = arb_bus.data_sel_i;
            bus_addr_d  = arb_bus.data_addr_i;
            bus_wdata_d = arb_bus.data_wdata_i;
          end else begin
            bus_we_d    = 1'b0;
            bus_sel_d   = '1;
            bus_addr_d  = arb_bus.inst_addr_i;
            bus_wdata_d = '0;
          end
        end
      end
      // A response coincident with the grant is not legal and is ignored here.
      ArbAddr: begin
        if (arb_bus.bus_gnt_i) begin
          state_d = ArbResp;
        end
      end
      ArbResp: begin
        if (arb_bus.bus_rvalid_i) begin
          state_d = ArbIdle;
          if (owner_q == OwnerData) begin
            data_rdata_d = arb_bus.bus_rdata_i;
            data_done_d  = 1'b1;
          end else begin
            inst_rdata_d = arb_bus.bus_rdata_i;
            inst_done_d  = 1'b1;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ArbIdle;
      owner_q      <= OwnerInst;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= OwnerInst;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bus_we_q     <= bus_we_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign arb_bus.bus_req_o    = (state_q == ArbAddr);
  assign arb_bus.bus_we_o     = bus_we_q;
  assign arb_bus.bus_sel_o    = bus_sel_q;
  assign arb_bus.bus_addr_o   = bus_addr_q;
  assign arb_bus.bus_wdata_o  = bus_wdata_q;
  assign arb_bus.inst_rdata_o = inst_rdata_q;
  assign arb_bus.inst_done_o  = inst_done_q;
  assign arb_bus.data_rdata_o = data_rdata_q;
  assign arb_bus.data_done_o  = data_done_q;
  assign arb_bus.stall_req_o  = (arb_bus.inst_req_i & ~inst_done_q) |
                                (arb_bus.data_req_i & ~data_done_q);

endmodule
